// File: rtl/tape_cache_bram_if.sv
// Bus between the tape loader and its image cache: the host download
// (write) channel and the loader's registered read port.
interface tape_cache_bram_if #(
  parameter int ADDR_W = 16
);
  // Host download channel
  logic              bram_download;
  logic              bram_wr;
  logic [24:0]       bram_init_address;
  logic [7:0]        bram_din;

  // Loader read port
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;

  // Loader side plus download host: drives requests, receives read data
  modport master (
    output bram_download, bram_wr, bram_init_address, bram_din,
    output cs, addr,
    input  dout
  );

  // Cache side: receives requests, returns read data
  modport slave (
    input  bram_download, bram_wr, bram_init_address, bram_din,
    input  cs, addr,
    output dout
  );
endinterface

// File: rtl/tape_cache_bram.sv
// Byte-wide single-clock cache for a downloaded cassette image.
// The write side accepts download bytes at full clock rate. The read side
// is registered with one cycle of latency and is read-first on collisions.
// The array is coded so that it maps onto a single block RAM.
module tape_cache_bram #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  tape_cache_bram_if.slave       bus
);

  logic [7:0]        mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        dout_q;

  // Qualify the download strobe: only in-range offsets outside reset land.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so that no path leaves it unassigned and implies a latch.
    wr_en   = 1'b0;
    wr_addr = bus.bram_init_address[ADDR_W-1:0];
    if (!reset && bus.bram_download && bus.bram_wr &&
        (bus.bram_init_address[24:ADDR_W] == '0)) begin
      wr_en = 1'b1;
    end
  end

  // Array write port; offsets at or beyond DEPTH are dropped, never wrapped.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset branch. Clearing it would need
    // per-word reset logic, which stops it mapping to block RAM, and the
    // contents are not required to be defined after reset.
    if (wr_en) begin
      mem[wr_addr] <= bus.bram_din;
    end
  end

  // Registered read port; holds its value while cs is low.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read sample the array before
    // this edge's write has landed. A same-address collision therefore
    // returns the old byte (read-first).
    if (reset) begin
      dout_q <= 8'h00;
    end else if (bus.cs) begin
      dout_q <= mem[bus.addr];
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_tape_cache_bram.sv
// Directed bench for tape_cache_bram: image download and readback, then a
// table of single-cycle vectors covering the corner cases.
module tb_tape_cache_bram;

  localparam int ADDR_W = 16;
  localparam int N_IMG  = 54;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tape_cache_bram_if #(.ADDR_W(ADDR_W)) bus ();

  tape_cache_bram #(.ADDR_W(ADDR_W), .DEPTH(65536)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        dl;
    logic        wr;
    logic [24:0] wa;
    logic [7:0]  din;
    logic        cs;
    logic [15:0] addr;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] img [N_IMG];

  function automatic vec_t mk(string name, logic rst, logic dl, logic wr,
                              logic [24:0] wa, logic [7:0] din, logic cs,
                              logic [15:0] addr, logic [7:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.dl = dl; v.wr = wr; v.wa = wa;
    v.din = din; v.cs = cs; v.addr = addr; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: dout=%02h expected=%02h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then sample away from it.
  task automatic drive(logic rst, logic dl, logic wr, logic [24:0] wa,
                       logic [7:0] din, logic cs, logic [15:0] addr);
    reset                 = rst;
    bus.bram_download     = dl;
    bus.bram_wr           = wr;
    bus.bram_init_address = wa;
    bus.bram_din          = din;
    bus.cs                = cs;
    bus.addr              = addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] head [14];
    head = '{8'h16, 8'h16, 8'h16, 8'h16, 8'h24, 8'hFF, 8'hFF,
             8'h00, 8'h00, 8'h05, 8'h1F, 8'h05, 8'h01, 8'h03};
    for (int i = 0; i < N_IMG; i++) begin
      img[i] = (i < 14) ? head[i] : 8'(8'h40 + i);
    end

    // Corner-case vectors; exp is dout after the edge on which they apply.
    // Readback leaves dout = img[53] = 8'h75.
    vecs.push_back(mk("wr_without_download", 0, 0, 1, 25'd5,       8'hAA, 0, 16'd0,    8'h75));
    vecs.push_back(mk("read0",               0, 0, 0, 25'd0,       8'h00, 1, 16'd0,    8'h16));
    vecs.push_back(mk("read5_not_written",   0, 0, 0, 25'd0,       8'h00, 1, 16'd5,    8'hFF));
    vecs.push_back(mk("wr_oob_10005",        0, 1, 1, 25'h0010005, 8'h55, 0, 16'd0,    8'hFF));
    vecs.push_back(mk("read0_again",         0, 0, 0, 25'd0,       8'h00, 1, 16'd0,    8'h16));
    vecs.push_back(mk("read5_no_alias",      0, 0, 0, 25'd0,       8'h00, 1, 16'd5,    8'hFF));
    vecs.push_back(mk("wr_top_inrange",      0, 1, 1, 25'h000FFFF, 8'h5A, 0, 16'd0,    8'hFF));
    vecs.push_back(mk("wr_top_bit24",        0, 1, 1, 25'h100FFFF, 8'hA5, 0, 16'd0,    8'hFF));
    vecs.push_back(mk("read_ffff",           0, 0, 0, 25'd0,       8'h00, 1, 16'hFFFF, 8'h5A));
    vecs.push_back(mk("read4",               0, 0, 0, 25'd0,       8'h00, 1, 16'd4,    8'h24));
    vecs.push_back(mk("cs_low_hold1",        0, 0, 0, 25'd0,       8'h00, 0, 16'd9,    8'h24));
    vecs.push_back(mk("cs_low_hold2",        0, 0, 0, 25'd0,       8'h00, 0, 16'd9,    8'h24));
    vecs.push_back(mk("cs_high_again",       0, 0, 0, 25'd0,       8'h00, 1, 16'd9,    8'h05));
    vecs.push_back(mk("collide_read_first",  0, 1, 1, 25'd3,       8'h77, 1, 16'd3,    8'h16));
    vecs.push_back(mk("collide_next_read",   0, 0, 0, 25'd0,       8'h00, 1, 16'd3,    8'h77));
    vecs.push_back(mk("rw_diff_read",        0, 1, 1, 25'd20,      8'h88, 1, 16'd10,   8'h1F));
    vecs.push_back(mk("rw_diff_write",       0, 0, 0, 25'd0,       8'h00, 1, 16'd20,   8'h88));
    vecs.push_back(mk("reset_cycle1",        1, 1, 1, 25'd30,      8'hC3, 1, 16'd4,    8'h00));
    vecs.push_back(mk("reset_cycle2",        1, 1, 1, 25'd31,      8'hC4, 1, 16'd4,    8'h00));
    vecs.push_back(mk("resume_rd30_kept",    0, 1, 1, 25'd32,      8'hC5, 1, 16'd30,   8'h5E));
    vecs.push_back(mk("rd31_kept",           0, 0, 0, 25'd0,       8'h00, 1, 16'd31,   8'h5F));
    vecs.push_back(mk("rd32_resumed_write",  0, 0, 0, 25'd0,       8'h00, 1, 16'd32,   8'hC5));
    vecs.push_back(mk("rd29_intact",         0, 0, 0, 25'd0,       8'h00, 1, 16'd29,   8'h5D));

    // Reset state
    drive(1, 0, 0, 25'd0, 8'h00, 0, 16'd0);
    drive(1, 0, 0, 25'd0, 8'h00, 1, 16'd0);
    check("reset_dout", bus.dout, 8'h00);

    // Download the image back to back, read port idle: dout must stay 0.
    for (int i = 0; i < N_IMG; i++) begin
      drive(0, 1, 1, 25'(i), img[i], 0, 16'd0);
    end
    check("idle_during_download", bus.dout, 8'h00);

    // Read back with the address changing every cycle.
    for (int i = 0; i < N_IMG; i++) begin
      drive(0, 0, 0, 25'd0, 8'h00, 1, 16'(i));
      check($sformatf("readback_%0d", i), bus.dout, img[i]);
    end

    // Table-driven corner cases
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].dl, vecs[i].wr, vecs[i].wa, vecs[i].din,
            vecs[i].cs, vecs[i].addr);
      check(vecs[i].name, bus.dout, vecs[i].exp);
    end

    // Hand sequence: reset with cs low still forces dout to zero, then a
    // write of the byte just read must not disturb the held value.
    drive(1, 0, 0, 25'd0, 8'h00, 0, 16'd0);
    check("reset_cs_low", bus.dout, 8'h00);
    drive(0, 0, 0, 25'd0, 8'h00, 1, 16'd10);
    check("post_reset_read10", bus.dout, 8'h1F);
    drive(0, 1, 1, 25'd10, 8'hE1, 0, 16'd10);
    check("hold_over_write", bus.dout, 8'h1F);
    drive(0, 0, 0, 25'd0, 8'h00, 1, 16'd10);
    check("read10_new", bus.dout, 8'hE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tape_cache_bram.md
Name: tape_cache_bram

Overview:
- Byte-wide single-clock RAM that caches a downloaded tape image for the cassette loader.
- Write port is driven by the host download channel (ioctl stream).
- Read port is driven by the tape-header/program-copy state machine.
- Synchronous read, one cycle of latency.

Parameters:
- ADDR_W, 16, width of the read address; also the number of download-address LSBs used for writes.
- DEPTH, 65536, number of bytes stored; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bram_download  input  1  high while a host download is in progress; qualifies writes.
- bram_wr  input  1  write strobe for one download byte.
- bram_init_address  input  25  byte offset of the download byte within the image.
- bram_din  input  8  download data byte.
- addr  input  ADDR_W  read address.
- dout  output  8  registered read data.
- cs  input  1  read enable / chip select.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Storage: DEPTH x 8-bit array. Contents are undefined at power-up. Reset does not clear contents.

Write port:
- Write condition: at a rising edge with reset=0, bram_download=1, bram_wr=1 and bram_init_address[24:ADDR_W]==0. Then mem[bram_init_address[ADDR_W-1:0]] <= bram_din.
- Addresses >= DEPTH (any upper bit set) are silently dropped. There is no wrap into low memory.
- bram_wr with bram_download=0 is ignored.
- While reset=1, all writes are ignored.

Read port:
- If reset=1: dout <= 8'h00.
- Else if cs=1: dout <= mem[addr]. Data is valid on the cycle after addr is presented (latency 1).
- Else (cs=0): dout holds its previous value.
- dout reset value is 8'h00.

Collisions and timing:
- Read and write to the same address in the same cycle: read-first. dout returns the old byte; the new byte is visible from the next read.
- Reads and writes to different addresses in the same cycle both complete.
- Back-to-back writes every cycle are supported, as are back-to-back reads with addr changing every cycle.
- No handshake or back-pressure; the download channel may write at full clock rate.

Reset mid-operation:
- Reset asserted during a download drops the writes of those cycles.
- Bytes already written are preserved; writes resume when reset deasserts.

Implementation:
- Must infer a single block RAM (registered read, no read-side reset on the array itself).

Test Plan:
- Download 54 bytes (16 16 16 16 24 FF FF 00 00 05 1F 05 01 03 ...) at addresses 0..53, then cs=1 and read addr 0..53 -> dout matches each byte one cycle after its addr (addr 4 -> 8'h24, addr 10 -> 8'h1F).
- bram_wr=1 with bram_download=0, addr 5, data 8'hAA -> subsequent read of addr 5 still returns the previously downloaded 8'hFF.
- Write to bram_init_address=25'h10005, data 8'h55 -> addr 5 unchanged (8'hFF); no aliasing.
- Read addr 4 with cs=1 (dout=8'h24), then cs=0 and addr=9 -> dout stays 8'h24 until cs returns high, then becomes 8'h05 one cycle later.
- Same-cycle write 8'h77 to addr 3 and read of addr 3 -> dout=8'h16 (old value); next-cycle read -> 8'h77.
- Assert reset for 2 cycles mid-download -> dout=8'h00; bytes written before reset read back intact; bytes presented during reset are not stored.
